renode_apb3_requester: RTL and testbench

- APB3 requester (manager) that drives the signal set of the renode_apb3_if bundle from a simple valid/ready command port.
- Sits between a Renode-side or RTL-side transaction source and an APB3 completer.
- Converts each accepted command into one APB3 SETUP+ACCESS transfer and returns read data, PSLVERR, and a timeout flag on a valid/ready response port.

---
 rtl/renode_apb3_pkg.sv | 17 +
 rtl/renode_apb3_timeout_counter.sv | 36 +++
 rtl/renode_apb3_requester.sv | 153 +++++++++++++++
 tb/tb_renode_apb3_requester.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/renode_apb3_pkg.sv
// Shared types and helpers for the Renode APB3 requester.
package renode_apb3_pkg;

  // Requester transfer phases.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    RESPOND = 2'd3
  } apb3_req_state_e;

  // APB3 data buses on this fabric are whole bytes, up to 32 bits wide.
  function automatic bit legal_data_width(input int width);
    return (width == 8) || (width == 16) || (width == 24) || (width == 32);
  endfunction

endpackage

// File: rtl/renode_apb3_timeout_counter.sv
// Counts ACCESS-phase wait cycles and flags the cycle in which the limit is hit.
// expired is combinational so the requester can leave ACCESS on the same edge
// that would have brought the count to the limit. A limit of 0 never expires.
module renode_apb3_timeout_counter
  import renode_apb3_pkg::*;
#(
  parameter int Width = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [Width-1:0] limit,
  output logic             expired
);

  logic [Width-1:0] count_reg;
  logic [Width-1:0] limit_m1;

  assign limit_m1 = limit - Width'(1);

  // The current wait cycle is the last allowed one when count == limit - 1.
  assign expired = (limit != '0) && enable && (count_reg == limit_m1);

  // Saturating wait-cycle count, restarted for each new transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != limit)) begin
      count_reg <= count_reg + Width'(1);
    end
  end

endmodule

// File: rtl/renode_apb3_requester.sv
// APB3 requester: turns valid/ready commands into SETUP+ACCESS transfers and
// returns read data, slave error and timeout status on a valid/ready response.
module renode_apb3_requester
  import renode_apb3_pkg::*;
#(
  parameter int AddressWidth  = 20,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [AddressWidth-1:0] cmd_addr,
  input  logic                    cmd_write,
  input  logic [DataWidth-1:0]    cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DataWidth-1:0]    rsp_rdata,
  output logic                    rsp_error,
  output logic                    rsp_timeout,
  output logic [AddressWidth-1:0] paddr,
  output logic                    pselx,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DataWidth-1:0]    pwdata,
  input  logic                    pready,
  input  logic [DataWidth-1:0]    prdata,
  input  logic                    pslverr
);

  if (!legal_data_width(DataWidth)) begin : g_bad_data_width
    $error("renode_apb3_requester: DataWidth must be 8, 16, 24 or 32");
  end

  // A zero TimeoutCycles still needs a 1-bit counter to keep widths legal.
  localparam int CntWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntWidth-1:0] Limit = CntWidth'(TimeoutCycles);

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 error;
    logic                 timeout;
  } apb3_rsp_t;

  apb3_req_state_e         state_reg;
  apb3_rsp_t               rsp_reg;
  logic                    rsp_valid_reg;
  logic [AddressWidth-1:0] paddr_reg;
  logic                    pselx_reg;
  logic                    penable_reg;
  logic                    pwrite_reg;
  logic [DataWidth-1:0]    pwdata_reg;
  logic                    accept;
  logic                    wait_cycle;
  logic                    expired;

  // Ready in IDLE, or in RESPOND as soon as the current response is consumed;
  // held low while reset is asserted so every output reads 0 in reset.
  assign cmd_ready  = !preset &&
                      ((state_reg == IDLE) || ((state_reg == RESPOND) && rsp_ready));
  assign accept     = cmd_valid && cmd_ready;
  assign wait_cycle = (state_reg == ACCESS) && !pready;

  assign rsp_valid   = rsp_valid_reg;
  assign rsp_rdata   = rsp_reg.rdata;
  assign rsp_error   = rsp_reg.error;
  assign rsp_timeout = rsp_reg.timeout;
  assign paddr       = paddr_reg;
  assign pselx       = pselx_reg;
  assign penable     = penable_reg;
  assign pwrite      = pwrite_reg;
  assign pwdata      = pwdata_reg;

  renode_apb3_timeout_counter #(
    .Width (CntWidth)
  ) u_timeout (
    .clk     (pclk),
    .rst     (preset),
    .clear   (accept),
    .enable  (wait_cycle),
    .limit   (Limit),
    .expired (expired)
  );

  // Transfer sequencer with registered APB and response outputs.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_reg     <= IDLE;
      rsp_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      paddr_reg     <= '0;
      pselx_reg     <= 1'b0;
      penable_reg   <= 1'b0;
      pwrite_reg    <= 1'b0;
      pwdata_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            paddr_reg   <= cmd_addr;
            pwrite_reg  <= cmd_write;
            pwdata_reg  <= cmd_wdata;
            pselx_reg   <= 1'b1;
            penable_reg <= 1'b0;
            state_reg   <= SETUP;
          end
        end
        SETUP: begin
          penable_reg <= 1'b1;
          state_reg   <= ACCESS;
        end
        ACCESS: begin
          // pready has priority over a timeout expiring in the same cycle.
          if (pready) begin
            rsp_reg.rdata   <= pwrite_reg ? '0 : prdata;
            rsp_reg.error   <= pslverr;
            rsp_reg.timeout <= 1'b0;
            pselx_reg       <= 1'b0;
            penable_reg     <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            state_reg       <= RESPOND;
          end else if (expired) begin
            rsp_reg.rdata   <= '0;
            rsp_reg.error   <= 1'b1;
            rsp_reg.timeout <= 1'b1;
            pselx_reg       <= 1'b0;
            penable_reg     <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            state_reg       <= RESPOND;
          end
        end
        RESPOND: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            if (cmd_valid) begin
              paddr_reg   <= cmd_addr;
              pwrite_reg  <= cmd_write;
              pwdata_reg  <= cmd_wdata;
              pselx_reg   <= 1'b1;
              penable_reg <= 1'b0;
              state_reg   <= SETUP;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_renode_apb3_requester.sv
// Directed testbench for the Renode APB3 requester.
module tb_renode_apb3_requester;

  localparam int AW = 20;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          pclk = 1'b0;
  logic          preset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic          cmd_write;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic          rsp_timeout;
  logic [AW-1:0] paddr;
  logic          pselx;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;

  int pass_cnt  = 0;
  int total_cnt = 0;

  renode_apb3_requester #(
    .AddressWidth  (AW),
    .DataWidth     (DW),
    .TimeoutCycles (TO)
  ) dut (
    .pclk        (pclk),
    .preset      (preset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_write   (cmd_write),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .rsp_timeout (rsp_timeout),
    .paddr       (paddr),
    .pselx       (pselx),
    .penable     (penable),
    .pwrite      (pwrite),
    .pwdata      (pwdata),
    .pready      (pready),
    .prdata      (prdata),
    .pslverr     (pslverr)
  );

  always #5 pclk = ~pclk;

  // Step to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    preset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0;
    rsp_ready = 1'b0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    #2;
    total_cnt++;
    if ({pselx, penable, rsp_valid, cmd_ready, pwrite} !== 5'b0)
      $display("FAIL rst_ctrl: got %b want 00000", {pselx, penable, rsp_valid, cmd_ready, pwrite});
    else pass_cnt++;
    total_cnt++;
    if ({paddr, pwdata, rsp_rdata, rsp_error, rsp_timeout} !== '0)
      $display("FAIL rst_data: paddr=%h pwdata=%h rdata=%h err=%b to=%b want all 0",
               paddr, pwdata, rsp_rdata, rsp_error, rsp_timeout);
    else pass_cnt++;
    tick(); tick();
    preset = 1'b0;
    #1;
    total_cnt++;
    if (cmd_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", cmd_ready);
    else pass_cnt++;
    $display("txn reset: cmd_ready=%b", cmd_ready);
  endtask

  task automatic test_zero_wait_write();
    cmd_addr = 20'h00010; cmd_write = 1'b1; cmd_wdata = 32'hDEADBEEF; cmd_valid = 1'b1;
    pready = 1'b1; rsp_ready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    total_cnt++;
    if ({pselx, penable, pwrite, paddr, pwdata, rsp_valid} !== {1'b1, 1'b0, 1'b1, 20'h00010, 32'hDEADBEEF, 1'b0})
      $display("FAIL wr_setup: psel=%b pen=%b pwr=%b paddr=%h pwdata=%h rv=%b want 1 0 1 00010 deadbeef 0",
               pselx, penable, pwrite, paddr, pwdata, rsp_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({pselx, penable, rsp_valid} !== 3'b110)
      $display("FAIL wr_access: psel/pen/rv=%b want 110", {pselx, penable, rsp_valid});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({rsp_valid, pselx, penable, rsp_error, rsp_timeout, rsp_rdata, paddr} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 20'h00010})
      $display("FAIL wr_rsp: rv=%b psel=%b pen=%b err=%b to=%b rdata=%h paddr=%h want 1 0 0 0 0 00000000 00010",
               rsp_valid, pselx, penable, rsp_error, rsp_timeout, rsp_rdata, paddr);
    else pass_cnt++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0; pready = 1'b0;
    total_cnt++;
    if (rsp_valid !== 1'b0) $display("FAIL wr_consume: rv=%b want 0", rsp_valid);
    else pass_cnt++;
    $display("txn write addr=00010 data=deadbeef err=%b", rsp_error);
  endtask

  task automatic test_wait_read();
    int en_cnt = 0;
    bit addr_ok = 1'b1;
    cmd_addr = 20'h00F00; cmd_write = 1'b0; cmd_wdata = 32'hA5A5A5A5; cmd_valid = 1'b1;
    pready = 1'b0; prdata = 32'h0;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (penable === 1'b1) en_cnt++;
      if (paddr !== 20'h00F00) addr_ok = 1'b0;
      tick();
    end
    prdata = 32'h12345678; pready = 1'b1;
    if (penable === 1'b1) en_cnt++;
    if (paddr !== 20'h00F00) addr_ok = 1'b0;
    tick();
    pready = 1'b0;
    total_cnt++;
    if (en_cnt !== 4) $display("FAIL rd_wait_penable: cycles=%0d want 4", en_cnt);
    else pass_cnt++;
    total_cnt++;
    if (addr_ok !== 1'b1) $display("FAIL rd_wait_paddr_stable: got %b want 1", addr_ok);
    else pass_cnt++;
    total_cnt++;
    if ({rsp_valid, rsp_rdata, rsp_error, rsp_timeout, pwrite} !== {1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0})
      $display("FAIL rd_wait_rsp: rv=%b rdata=%h err=%b to=%b pwr=%b want 1 12345678 0 0 0",
               rsp_valid, rsp_rdata, rsp_error, rsp_timeout, pwrite);
    else pass_cnt++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    $display("txn read addr=00f00 data=%h", rsp_rdata);
  endtask

  task automatic test_slave_error();
    cmd_addr = 20'h00ABC; cmd_write = 1'b0; cmd_valid = 1'b1;
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hCAFE0000;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    pslverr = 1'b0; pready = 1'b0;
    total_cnt++;
    if ({rsp_valid, rsp_error, rsp_timeout, rsp_rdata} !== {1'b1, 1'b1, 1'b0, 32'hCAFE0000})
      $display("FAIL slverr_rsp: rv=%b err=%b to=%b rdata=%h want 1 1 0 cafe0000",
               rsp_valid, rsp_error, rsp_timeout, rsp_rdata);
    else pass_cnt++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    $display("txn read addr=00abc err=1");
  endtask

  task automatic test_timeout();
    int n = 0;
    cmd_addr = 20'h12345; cmd_write = 1'b0; cmd_valid = 1'b1;
    pready = 1'b0; prdata = 32'hFFFFFFFF;
    tick();
    cmd_valid = 1'b0;
    tick();
    while ((penable === 1'b1) && (n < 40)) begin
      n++;
      tick();
    end
    total_cnt++;
    if (n !== TO) $display("FAIL timeout_cycles: access cycles=%0d want %0d", n, TO);
    else pass_cnt++;
    total_cnt++;
    if ({pselx, rsp_valid, rsp_error, rsp_timeout, rsp_rdata} !== {1'b0, 1'b1, 1'b1, 1'b1, 32'h0})
      $display("FAIL timeout_rsp: psel=%b rv=%b err=%b to=%b rdata=%h want 0 1 1 1 00000000",
               pselx, rsp_valid, rsp_error, rsp_timeout, rsp_rdata);
    else pass_cnt++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    $display("txn read addr=12345 timeout after %0d cycles", n);
  endtask

  task automatic test_timeout_boundary();
    cmd_addr = 20'h00044; cmd_write = 1'b0; cmd_valid = 1'b1;
    pready = 1'b0; prdata = 32'h0;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < TO - 1; i++) tick();
    total_cnt++;
    if ({pselx, penable, rsp_valid} !== 3'b110)
      $display("FAIL tob_last_access: psel/pen/rv=%b want 110", {pselx, penable, rsp_valid});
    else pass_cnt++;
    pready = 1'b1; prdata = 32'h0BADF00D;
    tick();
    pready = 1'b0;
    total_cnt++;
    if ({rsp_valid, rsp_error, rsp_timeout, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0BADF00D})
      $display("FAIL tob_pready_wins: rv=%b err=%b to=%b rdata=%h want 1 0 0 0badf00d",
               rsp_valid, rsp_error, rsp_timeout, rsp_rdata);
    else pass_cnt++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    $display("txn read addr=00044 data=%h on last cycle", rsp_rdata);
  endtask

  task automatic test_back_to_back();
    bit hold_ok = 1'b1;
    cmd_addr = 20'h00100; cmd_write = 1'b1; cmd_wdata = 32'h1; cmd_valid = 1'b1;
    pready = 1'b1; rsp_ready = 1'b0; prdata = 32'h00000222;
    tick();
    cmd_addr = 20'h00200; cmd_write = 1'b0; cmd_wdata = 32'h2;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      if ({rsp_valid, rsp_rdata, rsp_error, cmd_ready, pselx} !== {1'b1, 32'h0, 1'b0, 1'b0, 1'b0})
        hold_ok = 1'b0;
      tick();
    end
    total_cnt++;
    if (hold_ok !== 1'b1) $display("FAIL b2b_backpressure_hold: got %b want 1", hold_ok);
    else pass_cnt++;
    rsp_ready = 1'b1;
    #1;
    total_cnt++;
    if (cmd_ready !== 1'b1) $display("FAIL b2b_ready_follows: got %b want 1", cmd_ready);
    else pass_cnt++;
    tick();
    cmd_addr = 20'h00300; cmd_write = 1'b1; cmd_wdata = 32'h333;
    total_cnt++;
    if ({pselx, penable, rsp_valid, paddr} !== {1'b1, 1'b0, 1'b0, 20'h00200})
      $display("FAIL b2b_second_setup: psel=%b pen=%b rv=%b paddr=%h want 1 0 0 00200",
               pselx, penable, rsp_valid, paddr);
    else pass_cnt++;
    tick(); tick();
    total_cnt++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h00000222})
      $display("FAIL b2b_second_rsp: rv=%b rdata=%h want 1 00000222", rsp_valid, rsp_rdata);
    else pass_cnt++;
    tick();
    cmd_valid = 1'b0;
    total_cnt++;
    if ({pselx, penable, rsp_valid, pwrite, paddr, pwdata} !== {1'b1, 1'b0, 1'b0, 1'b1, 20'h00300, 32'h333})
      $display("FAIL b2b_third_setup: psel=%b pen=%b rv=%b pwr=%b paddr=%h pwdata=%h want 1 0 0 1 00300 00000333",
               pselx, penable, rsp_valid, pwrite, paddr, pwdata);
    else pass_cnt++;
    tick(); tick();
    total_cnt++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0})
      $display("FAIL b2b_third_rsp: rv=%b rdata=%h want 1 00000000", rsp_valid, rsp_rdata);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({rsp_valid, pselx, cmd_ready} !== 3'b001)
      $display("FAIL b2b_idle: rv/psel/ready=%b want 001", {rsp_valid, pselx, cmd_ready});
    else pass_cnt++;
    rsp_ready = 1'b0; pready = 1'b0;
    $display("txn back-to-back 00100/00200/00300 done");
  endtask

  task automatic test_reset_mid_access();
    cmd_addr = 20'h00777; cmd_write = 1'b0; cmd_valid = 1'b1; pready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    total_cnt++;
    if ({pselx, penable} !== 2'b11) $display("FAIL mid_rst_in_access: psel/pen=%b want 11", {pselx, penable});
    else pass_cnt++;
    #2;
    preset = 1'b1;
    #1;
    total_cnt++;
    if ({pselx, penable, rsp_valid} !== 3'b000)
      $display("FAIL mid_rst_async: psel/pen/rv=%b want 000", {pselx, penable, rsp_valid});
    else pass_cnt++;
    #2;
    preset = 1'b0;
    pready = 1'b1;
    tick();
    total_cnt++;
    if ({cmd_ready, rsp_valid, pselx} !== 3'b100)
      $display("FAIL mid_rst_idle: ready/rv/psel=%b want 100", {cmd_ready, rsp_valid, pselx});
    else pass_cnt++;
    tick(); tick(); tick();
    total_cnt++;
    if ({rsp_valid, pselx} !== 2'b00)
      $display("FAIL mid_rst_no_stale: rv/psel=%b want 00", {rsp_valid, pselx});
    else pass_cnt++;
    pready = 1'b0;
    $display("txn reset mid-access, transfer discarded");
  endtask

  initial begin
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_slave_error();
    test_timeout();
    test_timeout_boundary();
    test_back_to_back();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule
